// File: rtl/vj_ii_writer.sv
// Integral-image writer: turns a row-major 8-bit pixel stream into an
// (IMG_W+1) x (IMG_H+1) integral image written one word per cycle.
module vj_ii_writer #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int II_W      = 321,
  parameter int ADDR_W    = 17,
  parameter int II_DATA_W = 32,
  parameter int PIX_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 pix_valid,
  input  logic [PIX_W-1:0]     pix_data,
  output logic                 pix_ready,
  output logic                 ii_we,
  output logic [ADDR_W-1:0]    ii_waddr,
  output logic [II_DATA_W-1:0] ii_wdata,
  output logic                 busy,
  output logic                 done
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_END  = XW'(IMG_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR0,
    S_ROWST,
    S_PIX,
    S_FIN
  } state_t;

  state_t                 state_reg, state_next;
  logic [XW-1:0]          x_reg, x_next;
  logic [YW-1:0]          y_reg, y_next;
  logic [ADDR_W-1:0]      row_base_reg, row_base_next;
  logic [II_DATA_W-1:0]   row_sum_reg, row_sum_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   we_reg, we_next;
  logic [ADDR_W-1:0]      waddr_reg, waddr_next;
  logic [II_DATA_W-1:0]   wdata_reg, wdata_next;

  // Previous II row; read is registered, so the next column is prefetched.
  logic [II_DATA_W-1:0]   linebuf [0:IMG_W];
  logic [II_DATA_W-1:0]   linebuf_q;
  logic                   lb_we;
  logic [XW-1:0]          lb_waddr;
  logic [XW-1:0]          lb_raddr;
  logic [II_DATA_W-1:0]   lb_wdata;

  logic                   accept;
  logic [II_DATA_W-1:0]   pix_ext;
  logic [II_DATA_W-1:0]   v;

  assign pix_ready = (state_reg == S_PIX);
  assign accept    = pix_valid && pix_ready;
  assign pix_ext   = II_DATA_W'(pix_data);
  assign v         = linebuf_q + row_sum_reg + pix_ext;

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    row_base_next = row_base_reg;
    row_sum_next  = row_sum_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    we_next       = 1'b0;
    waddr_next    = waddr_reg;
    wdata_next    = wdata_reg;
    lb_we         = 1'b0;
    lb_waddr      = x_reg;
    lb_wdata      = '0;
    lb_raddr      = x_reg + XW'(1);

    case (state_reg)
      S_IDLE: begin
        busy_next = 1'b0;
        if (start) begin
          busy_next  = 1'b1;
          x_next     = '0;
          state_next = S_CLR0;
        end
      end

      S_CLR0: begin
        we_next    = 1'b1;
        waddr_next = ADDR_W'(x_reg);
        wdata_next = '0;
        lb_we      = 1'b1;
        lb_waddr   = x_reg;
        if (x_reg == X_END) begin
          y_next        = YW'(1);
          row_base_next = ADDR_W'(II_W);
          state_next    = S_ROWST;
        end else begin
          x_next = x_reg + XW'(1);
        end
      end

      S_ROWST: begin
        we_next      = 1'b1;
        waddr_next   = row_base_reg;
        wdata_next   = '0;
        row_sum_next = '0;
        x_next       = '0;
        lb_raddr     = XW'(1);
        state_next   = S_PIX;
      end

      S_PIX: begin
        if (accept) begin
          // Fetch the column after the one being written so it is ready next cycle.
          lb_raddr     = (x_reg == X_LAST) ? x_reg + XW'(1) : x_reg + XW'(2);
          row_sum_next = row_sum_reg + pix_ext;
          lb_we        = 1'b1;
          lb_waddr     = x_reg + XW'(1);
          lb_wdata     = v;
          we_next      = 1'b1;
          waddr_next   = row_base_reg + ADDR_W'(x_reg) + ADDR_W'(1);
          wdata_next   = v;
          x_next       = x_reg + XW'(1);
          if (x_reg == X_LAST) begin
            if (y_reg < YW'(IMG_H)) begin
              y_next        = y_reg + YW'(1);
              row_base_next = row_base_reg + ADDR_W'(II_W);
              state_next    = S_ROWST;
            end else begin
              state_next = S_FIN;
            end
          end
        end
      end

      S_FIN: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      row_base_reg <= '0;
      row_sum_reg  <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      row_base_reg <= row_base_next;
      row_sum_reg  <= row_sum_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      we_reg       <= we_next;
      waddr_reg    <= waddr_next;
      wdata_reg    <= wdata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_waddr] <= lb_wdata;
    linebuf_q <= linebuf[lb_raddr];
  end

  assign ii_we    = we_reg;
  assign ii_waddr = waddr_reg;
  assign ii_wdata = wdata_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_vj_ii_writer.sv
// Bench for vj_ii_writer: a 4x3 instance for functional scenarios and a
// full 320x240 instance for the large-frame sum and cycle count.
module tb_vj_ii_writer;

  localparam int SW = 4, SH = 3, SIIW = 5, SAW = 5, SWORDS = 20, SPIX = 12;
  localparam int FW = 320, FH = 240, FIIW = 321, FAW = 17, FWORDS = 77361;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic           s_start = 0, s_valid = 0;
  logic [7:0]     s_data = 0;
  logic           s_ready, s_we, s_busy, s_done;
  logic [SAW-1:0] s_waddr;
  logic [31:0]    s_wdata;

  logic           f_start = 0, f_valid = 0;
  logic [7:0]     f_data = 0;
  logic           f_ready, f_we, f_busy, f_done;
  logic [FAW-1:0] f_waddr;
  logic [31:0]    f_wdata;

  vj_ii_writer #(.IMG_W(SW), .IMG_H(SH), .II_W(SIIW), .ADDR_W(SAW),
                 .II_DATA_W(32), .PIX_W(8)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(s_start), .pix_valid(s_valid),
    .pix_data(s_data), .pix_ready(s_ready), .ii_we(s_we), .ii_waddr(s_waddr),
    .ii_wdata(s_wdata), .busy(s_busy), .done(s_done));

  vj_ii_writer #(.IMG_W(FW), .IMG_H(FH), .II_W(FIIW), .ADDR_W(FAW),
                 .II_DATA_W(32), .PIX_W(8)) dut_f (
    .clk(clk), .reset_n(reset_n), .start(f_start), .pix_valid(f_valid),
    .pix_data(f_data), .pix_ready(f_ready), .ii_we(f_we), .ii_waddr(f_waddr),
    .ii_wdata(f_wdata), .busy(f_busy), .done(f_done));

  int checks = 0;
  int errors = 0;

  int unsigned pix_s [0:SPIX-1];
  logic [31:0] s_ram [0:SWORDS-1];
  int   s_writes = 0, s_dones = 0, s_bad = 0;
  logic s_acc_edge = 0;

  int   cyc_cnt = 0;
  int   f_writes = 0, f_bad = 0, f_gap = 0, f_first = -1, f_done_cyc = -1;
  logic [31:0] f_last = 0;

  // Reference: II(x,y) is the plain double sum of the pixels above-left.
  function automatic logic [31:0] ii_ref(input int x, input int y);
    logic [31:0] acc;
    acc = 0;
    for (int j = 0; j < y; j++)
      for (int i = 0; i < x; i++)
        acc += 32'(pix_s[j*SW + i]);
    return acc;
  endfunction

  always @(posedge clk) begin
    cyc_cnt    <= cyc_cnt + 1;
    s_acc_edge <= s_valid && s_ready;
  end

  always @(negedge clk) begin
    if (s_we) begin
      if (int'(s_waddr) < SWORDS) s_ram[s_waddr] = s_wdata;
      s_writes++;
      if (!(int'(s_waddr) < SIIW || (int'(s_waddr) % SIIW) == 0) && !s_acc_edge) s_bad++;
    end
    if (s_done) s_dones++;
  end

  always @(negedge clk) begin
    int xx, yy;
    if (f_we) begin
      if (f_writes == 0) f_first = cyc_cnt;
      yy = int'(f_waddr) / FIIW;
      xx = int'(f_waddr) % FIIW;
      if (f_wdata !== 32'(255 * xx * yy)) f_bad++;
      if (int'(f_waddr) == FWORDS - 1) f_last = f_wdata;
      f_writes++;
    end else if (f_writes > 0 && f_writes < FWORDS) begin
      f_gap++;
    end
    if (f_done) f_done_cyc = cyc_cnt;
  end

  // Drives one 4x3 frame; gap_pct drops pix_valid randomly, poke adds stray
  // start pulses and valid outside PIX, reset_at pulls reset after that many pixels.
  task automatic run_small(input int gap_pct, input bit poke, input int reset_at,
                           output bit finished);
    int idx, cyc, last_idx, stall_left;
    idx = 0; cyc = 0; last_idx = -1; stall_left = 0;
    finished = 0;
    for (int a = 0; a < SWORDS; a++) s_ram[a] = 32'hDEADBEEF;
    s_writes = 0; s_dones = 0; s_bad = 0;
    @(negedge clk);
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    while (cyc < 500) begin
      if (reset_at >= 0 && idx == reset_at) begin
        reset_n = 0;
        s_valid = 0;
        @(negedge clk);
        return;
      end
      if (idx < SPIX) begin
        if (idx != last_idx) begin
          last_idx   = idx;
          stall_left = (gap_pct > 0 && idx > 0 && (idx % SW) == 0) ? 4 : 0;
        end
        if (stall_left > 0) begin
          s_valid = 0;
          stall_left--;
        end else begin
          s_valid = (int'($urandom_range(99)) >= gap_pct);
        end
        s_data = 8'(pix_s[idx]);
      end else begin
        s_valid = poke;
        s_data  = 8'($urandom);
      end
      s_start = (poke && (cyc == 3 || cyc == 12)) ? 1'b1 : 1'b0;
      @(negedge clk);
      cyc++;
      if (s_acc_edge) idx++;
      if (s_done) begin
        finished = 1;
        break;
      end
    end
    s_valid = 0;
    s_start = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_busy, s_done, s_we, s_ready} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/done/we/ready=%b required 0000", {s_busy, s_done, s_we, s_ready});
    end
    checks++;
    if (s_waddr !== '0 || s_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus: got waddr=%0d wdata=%0d required 0/0", s_waddr, s_wdata);
    end
    checks++;
    if ({f_busy, f_done, f_we, f_ready} !== 4'b0 || f_waddr !== '0 || f_wdata !== '0) begin
      errors++;
      $display("FAIL reset_full: got busy/done/we/ready=%b waddr=%0d wdata=%0d required all 0",
               {f_busy, f_done, f_we, f_ready}, f_waddr, f_wdata);
    end
    reset_n = 1;
    @(negedge clk);
    $display("reset: outputs checked after reset");
  endtask

  task automatic test_all_ones();
    bit fin;
    for (int k = 0; k < SPIX; k++) pix_s[k] = 1;
    run_small(0, 0, -1, fin);
    checks++;
    if (!fin) begin errors++; $display("FAIL ones_timeout: done not seen within 500 cycles"); end
    checks++;
    if (s_ram[19] !== 32'd12) begin errors++; $display("FAIL ones_ii43: got %0d required 12", s_ram[19]); end
    checks++;
    if (s_ram[7] !== 32'd2) begin errors++; $display("FAIL ones_ii21: got %0d required 2", s_ram[7]); end
    for (int a = 0; a < SWORDS; a++) begin
      if (a < SIIW || (a % SIIW) == 0) begin
        checks++;
        if (s_ram[a] !== 32'd0) begin errors++; $display("FAIL ones_zero_edge: addr %0d got %0d required 0", a, s_ram[a]); end
      end
    end
    checks++;
    if (s_writes != SWORDS || s_dones != 1) begin
      errors++;
      $display("FAIL ones_counts: got writes=%0d dones=%0d required 20/1", s_writes, s_dones);
    end
    $display("all_ones: writes=%0d dones=%0d II(4,3)=%0d", s_writes, s_dones, s_ram[19]);
  endtask

  task automatic test_ramp();
    bit fin;
    int exp_row1 [0:4];
    exp_row1 = '{0, 0, 1, 3, 6};
    for (int j = 0; j < SH; j++)
      for (int i = 0; i < SW; i++) pix_s[j*SW + i] = i + j;
    run_small(0, 0, -1, fin);
    checks++;
    if (!fin) begin errors++; $display("FAIL ramp_timeout: done not seen within 500 cycles"); end
    for (int i = 0; i < SIIW; i++) begin
      checks++;
      if (s_ram[SIIW + i] !== 32'(exp_row1[i])) begin
        errors++;
        $display("FAIL ramp_row1: x=%0d got %0d required %0d", i, s_ram[SIIW + i], exp_row1[i]);
      end
    end
    checks++;
    if (s_ram[19] !== 32'd30) begin errors++; $display("FAIL ramp_ii43: got %0d required 30", s_ram[19]); end
    for (int a = 0; a < SWORDS; a++) begin
      checks++;
      if (s_ram[a] !== ii_ref(a % SIIW, a / SIIW)) begin
        errors++;
        $display("FAIL ramp_model: addr %0d got %0d required %0d", a, s_ram[a], ii_ref(a % SIIW, a / SIIW));
      end
    end
    $display("ramp: writes=%0d II(4,3)=%0d", s_writes, s_ram[19]);
  endtask

  task automatic test_gaps();
    bit fin;
    for (int j = 0; j < SH; j++)
      for (int i = 0; i < SW; i++) pix_s[j*SW + i] = i + j;
    run_small(50, 0, -1, fin);
    checks++;
    if (!fin) begin errors++; $display("FAIL gaps_timeout: done not seen within 500 cycles"); end
    for (int a = 0; a < SWORDS; a++) begin
      checks++;
      if (s_ram[a] !== ii_ref(a % SIIW, a / SIIW)) begin
        errors++;
        $display("FAIL gaps_model: addr %0d got %0d required %0d", a, s_ram[a], ii_ref(a % SIIW, a / SIIW));
      end
    end
    checks++;
    if (s_bad != 0 || s_writes != SWORDS) begin
      errors++;
      $display("FAIL gaps_writes: got unaccepted=%0d writes=%0d required 0/20", s_bad, s_writes);
    end
    $display("gaps: writes=%0d unaccepted_writes=%0d", s_writes, s_bad);
  endtask

  task automatic test_ignore();
    bit fin;
    for (int k = 0; k < SPIX; k++) pix_s[k] = $urandom_range(255);
    s_writes = 0;
    s_valid  = 1;
    s_data   = 8'hAA;
    repeat (5) @(negedge clk);
    checks++;
    if (s_writes != 0 || s_ready !== 1'b0 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got writes=%0d ready=%b busy=%b required 0/0/0", s_writes, s_ready, s_busy);
    end
    s_valid = 0;
    run_small(0, 1, -1, fin);
    repeat (6) @(negedge clk);
    checks++;
    if (!fin || s_dones != 1) begin
      errors++;
      $display("FAIL ignore_done: got finished=%0d dones=%0d required 1/1", fin, s_dones);
    end
    checks++;
    if (s_writes != SWORDS) begin errors++; $display("FAIL ignore_writes: got %0d required 20", s_writes); end
    for (int a = 0; a < SWORDS; a++) begin
      checks++;
      if (s_ram[a] !== ii_ref(a % SIIW, a / SIIW)) begin
        errors++;
        $display("FAIL ignore_model: addr %0d got %0d required %0d", a, s_ram[a], ii_ref(a % SIIW, a / SIIW));
      end
    end
    $display("ignore: writes=%0d dones=%0d", s_writes, s_dones);
  endtask

  task automatic test_reset_midframe();
    bit fin;
    for (int k = 0; k < SPIX; k++) pix_s[k] = $urandom_range(255);
    run_small(30, 0, 7, fin);
    checks++;
    if ({s_busy, s_we, s_done, s_ready} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_out: got busy/we/done/ready=%b required 0000", {s_busy, s_we, s_done, s_ready});
    end
    reset_n = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (s_dones != 0) begin errors++; $display("FAIL midreset_done: got %0d pulses required 0", s_dones); end
    for (int k = 0; k < SPIX; k++) pix_s[k] = $urandom_range(255);
    run_small(30, 0, -1, fin);
    checks++;
    if (!fin || s_dones != 1 || s_writes != SWORDS) begin
      errors++;
      $display("FAIL midreset_refr: got finished=%0d dones=%0d writes=%0d required 1/1/20", fin, s_dones, s_writes);
    end
    for (int a = 0; a < SWORDS; a++) begin
      checks++;
      if (s_ram[a] !== ii_ref(a % SIIW, a / SIIW)) begin
        errors++;
        $display("FAIL midreset_model: addr %0d got %0d required %0d", a, s_ram[a], ii_ref(a % SIIW, a / SIIW));
      end
    end
    $display("reset_midframe: new frame writes=%0d dones=%0d", s_writes, s_dones);
  endtask

  task automatic test_full_frame();
    int cyc;
    cyc = 0;
    f_writes = 0; f_bad = 0; f_gap = 0; f_first = -1; f_done_cyc = -1; f_last = 0;
    @(negedge clk);
    f_valid = 1;
    f_data  = 8'hFF;
    f_start = 1;
    @(negedge clk);
    f_start = 0;
    while (!f_done && cyc < 80000) begin
      @(negedge clk);
      cyc++;
    end
    f_valid = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (f_done_cyc < 0) begin errors++; $display("FAIL full_timeout: done not seen within 80000 cycles"); end
    checks++;
    if (f_last !== 32'd19584000) begin errors++; $display("FAIL full_last: got %0d required 19584000", f_last); end
    checks++;
    if (f_writes != FWORDS || f_bad != 0 || f_gap != 0) begin
      errors++;
      $display("FAIL full_words: got writes=%0d bad=%0d gaps=%0d required 77361/0/0", f_writes, f_bad, f_gap);
    end
    checks++;
    if (f_done_cyc - f_first != FWORDS) begin
      errors++;
      $display("FAIL full_cycles: got %0d cycles from first write to done required %0d", f_done_cyc - f_first, FWORDS);
    end
    $display("full_frame: writes=%0d last=%0d cycles=%0d", f_writes, f_last, f_done_cyc - f_first);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_ramp();
    test_gaps();
    test_ignore();
    test_reset_midframe();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
